// File: rtl/mpu401_fifo_uart.sv
// MPU-401 compatible MIDI port: CPU data/command pair, FIFO-buffered 8N1 TX and RX,
// UART/intelligent mode tracking with command acks and RX interrupt.
module mpu401_fifo_uart #(
   parameter int unsigned CLK_DIV  = 800,
   parameter int unsigned TX_DEPTH = 16,
   parameter int unsigned RX_DEPTH = 16
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       cs,
   input  logic       wr,
   input  logic       addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   input  logic       midi_in,
   output logic       midi_out
);
   localparam int unsigned TXA = $clog2(TX_DEPTH);
   localparam int unsigned RXA = $clog2(RX_DEPTH);
   localparam int unsigned CW  = $clog2(CLK_DIV);
   localparam logic [7:0]  ACK = 8'hFE;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

   logic [7:0]  tx_mem_q [TX_DEPTH];
   logic [7:0]  tx_mem_d [TX_DEPTH];
   logic [7:0]  rx_mem_q [RX_DEPTH];
   logic [7:0]  rx_mem_d [RX_DEPTH];
   logic [TXA:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [RXA:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic        mode_q, mode_d;
   logic        hold_v_q, hold_v_d;
   logic [7:0]  hold_q, hold_d;
   uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic        midi_out_q, midi_out_d;
   logic        sync1_q, sync2_q, sync3_q;

   logic tx_full_c, tx_empty_c, rx_full_c, rx_empty_c, tx_pop_c, rx_done_c;
   logic cmd_c, flush_c, ack_c, fresh_c, hold_live_c, rx_pop_c, rx_push_c;
   logic [7:0] rx_push_data_c, rd_data_c;
   logic [RXA:0] rx_wbase_c, rx_rbase_c;

   always_comb begin
      tx_empty_c = (tx_wp_q == tx_rp_q);
      tx_full_c  = (tx_wp_q[TXA] != tx_rp_q[TXA]) && (tx_wp_q[TXA-1:0] == tx_rp_q[TXA-1:0]);
      rx_empty_c = (rx_wp_q == rx_rp_q);
      rx_full_c  = (rx_wp_q[RXA] != rx_rp_q[RXA]) && (rx_wp_q[RXA-1:0] == rx_rp_q[RXA-1:0]);
      cmd_c      = cs && wr && addr;
      flush_c    = cmd_c && (din == 8'hFF);
      ack_c      = flush_c || (cmd_c && !mode_q);
      mode_d     = mode_q;
      if (flush_c)                                  mode_d = 1'b0;
      else if (cmd_c && !mode_q && din == 8'h3F)    mode_d = 1'b1;
   end

   // TX serialiser; the STOP bit chains straight into the next START when data is waiting
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_pop_c   = 1'b0;
      midi_out_d = 1'b1;
      case (tx_state_q)
         ST_IDLE: begin
            tx_cnt_d = '0;
            if (!tx_empty_c) begin
               tx_pop_c   = 1'b1;
               tx_sh_d    = tx_mem_q[tx_rp_q[TXA-1:0]];
               tx_state_d = ST_START;
            end
         end
         ST_START: begin
            midi_out_d = 1'b0;
            if (tx_cnt_q == CW'(CLK_DIV - 1)) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            midi_out_d = tx_sh_q[0];
            if (tx_cnt_q == CW'(CLK_DIV - 1)) begin
               tx_cnt_d = '0;
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
            end
         end
         default: begin
            if (tx_cnt_q == CW'(CLK_DIV - 1)) begin
               tx_cnt_d   = '0;
               tx_state_d = ST_IDLE;
               if (!tx_empty_c) begin
                  tx_pop_c   = 1'b1;
                  tx_sh_d    = tx_mem_q[tx_rp_q[TXA-1:0]];
                  tx_state_d = ST_START;
               end
            end
         end
      endcase
   end

   always_comb begin
      tx_mem_d = tx_mem_q;
      tx_rp_d  = tx_rp_q;
      tx_wp_d  = tx_wp_q;
      if (tx_pop_c) tx_rp_d = tx_rp_q + (TXA+1)'(1);
      if (cs && wr && !addr && (!tx_full_c || tx_pop_c)) begin
         tx_mem_d[tx_wp_q[TXA-1:0]] = din;
         tx_wp_d = tx_wp_q + (TXA+1)'(1);
      end
      if (flush_c) begin
         tx_rp_d = '0;
         tx_wp_d = '0;
      end
   end

   // RX deserialiser; returns to IDLE at mid-stop so the next start edge is caught
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CW'(1);
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_done_c  = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            if (sync3_q && !sync2_q) rx_state_d = ST_START;
         end
         ST_START: begin
            if (rx_cnt_q == CW'(CLK_DIV / 2 - 1)) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = sync2_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == CW'(CLK_DIV - 1)) begin
               rx_cnt_d = '0;
               rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            end
         end
         default: begin
            if (rx_cnt_q == CW'(CLK_DIV - 1)) begin
               rx_cnt_d   = '0;
               rx_state_d = ST_IDLE;
               rx_done_c  = sync2_q;
            end
         end
      endcase
   end

   // RX FIFO push arbitration: ack, then parked byte, then fresh byte
   always_comb begin
      rx_pop_c       = cs && !wr && !addr && !rx_empty_c;
      fresh_c        = rx_done_c && mode_d;
      hold_live_c    = hold_v_q && !flush_c;
      hold_v_d       = hold_live_c;
      hold_d         = hold_q;
      rx_push_c      = 1'b0;
      rx_push_data_c = ACK;
      if (ack_c) begin
         rx_push_c = 1'b1;
         if (!hold_live_c && fresh_c) begin
            hold_v_d = 1'b1;
            hold_d   = rx_sh_q;
         end
      end else if (hold_live_c) begin
         rx_push_c      = 1'b1;
         rx_push_data_c = hold_q;
         hold_v_d       = fresh_c;
         hold_d         = rx_sh_q;
      end else if (fresh_c) begin
         rx_push_c      = 1'b1;
         rx_push_data_c = rx_sh_q;
      end
      rx_wbase_c = flush_c ? '0 : rx_wp_q;
      rx_rbase_c = flush_c ? '0 : rx_rp_q;
      rx_mem_d   = rx_mem_q;
      rx_wp_d    = rx_wbase_c;
      rx_rp_d    = rx_pop_c ? rx_rbase_c + (RXA+1)'(1) : rx_rbase_c;
      if (rx_push_c && (flush_c || !rx_full_c || rx_pop_c)) begin
         rx_mem_d[rx_wbase_c[RXA-1:0]] = rx_push_data_c;
         rx_wp_d = rx_wbase_c + (RXA+1)'(1);
      end
   end

   always_comb begin
      if (addr) rd_data_c = {rx_empty_c, tx_full_c, 6'b111111};
      else      rd_data_c = rx_empty_c ? 8'hFF : rx_mem_q[rx_rp_q[RXA-1:0]];
   end

   assign dout     = cs ? rd_data_c : 8'hzz;
   assign irq      = mode_q && !rx_empty_c;
   assign midi_out = midi_out_q;

   always_ff @(posedge clk_sys) begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tx_wp_q    <= '0;
         tx_rp_q    <= '0;
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         mode_q     <= 1'b0;
         hold_v_q   <= 1'b0;
         hold_q     <= '0;
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         midi_out_q <= 1'b1;
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         sync3_q    <= 1'b1;
      end else begin
         tx_wp_q    <= tx_wp_d;
         tx_rp_q    <= tx_rp_d;
         rx_wp_q    <= rx_wp_d;
         rx_rp_q    <= rx_rp_d;
         mode_q     <= mode_d;
         hold_v_q   <= hold_v_d;
         hold_q     <= hold_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         midi_out_q <= midi_out_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         sync1_q    <= midi_in;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
      end
   end
endmodule
